// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if
//   Bus bundle between the requesters / shared multiplier and mul_arbiter.
//   Requester side : req_valid, req_a, req_b (in to arbiter), req_ready,
//                    rsp_valid, rsp_product (out of arbiter).
//   Multiplier side: mul_a, mul_b, mul_valid (out of arbiter),
//                    mul_product (in to arbiter).
//   Status         : busy (out of arbiter).
//   slave  modport : the arbiter's view.
//   master modport : the environment's view (requesters + multiplier).
interface mul_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [64*NUM_REQ-1:0] req_a;
  logic [64*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [127:0]          rsp_product;
  logic [63:0]           mul_a;
  logic [63:0]           mul_b;
  logic                  mul_valid;
  logic [127:0]          mul_product;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, mul_product,
    input  req_ready, rsp_valid, rsp_product, mul_a, mul_b, mul_valid, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_product,
    output req_ready, rsp_valid, rsp_product, mul_a, mul_b, mul_valid, busy
  );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter
//   Round-robin arbiter sharing one pipelined 64x64 multiplier between
//   NUM_REQ requesters. A granted request is registered onto mul_a/mul_b with
//   mul_valid; a tag (valid + requester index) travels alongside the
//   multiplier latency and, on exit, steers mul_product back to the owner as
//   a one-cycle rsp_valid strobe. Responses cannot be back-pressured.
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; flushes everything in flight
//   enable : gates new grants only; in-flight work still completes
//   bus    : mul_arbiter_if.slave (request, response and multiplier signals)
module mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  mul_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]       ptr;
  logic                   grant_vld;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       cand;
  logic [63:0]            sel_a;
  logic [63:0]            sel_b;
  logic [IDX_W-1:0]       issue_idx_p0;
  logic [MUL_LATENCY-1:0] tag_vld_p;
  logic [IDX_W-1:0]       tag_idx_p [MUL_LATENCY];
  logic                   out_vld;
  logic [IDX_W-1:0]       out_idx;

  // Arbitration: search starts one past the last winner, first valid wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (!grant_vld && bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (reset || !enable) begin
      grant_vld = 1'b0;
    end
  end

  assign bus.req_ready = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_a = bus.req_a[i*64 +: 64];
        sel_b = bus.req_b[i*64 +: 64];
      end
    end
  end

  // Issue stage -> multiplier; tag valid pipeline mirrors the multiplier latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= IDX_W'(NUM_REQ - 1);
      bus.mul_valid <= 1'b0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      tag_vld_p     <= '0;
    end else begin
      bus.mul_valid <= grant_vld;
      if (grant_vld) begin
        ptr       <= grant_idx;
        bus.mul_a <= sel_a;
        bus.mul_b <= sel_b;
      end
      tag_vld_p[0] <= bus.mul_valid;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
      end
    end
  end

  // Tag index pipeline; only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (grant_vld) begin
      issue_idx_p0 <= grant_idx;
    end
    tag_idx_p[0] <= issue_idx_p0;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      tag_idx_p[i] <= tag_idx_p[i-1];
    end
  end

  // Response stage: exiting tag lines up with mul_product this cycle.
  assign out_vld         = tag_vld_p[MUL_LATENCY-1];
  assign out_idx         = tag_idx_p[MUL_LATENCY-1];
  assign bus.rsp_valid   = out_vld ? (NUM_REQ'(1) << out_idx) : '0;
  assign bus.rsp_product = out_vld ? bus.mul_product : '0;
  assign bus.busy        = bus.mul_valid | (|tag_vld_p);

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;
  localparam int N = 4;

  typedef struct {
    int           hs;
    int           idx;
    logic [127:0] prod;
  } hs_t;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [N-1:0]     req_valid;
  logic [64*N-1:0]  req_a;
  logic [64*N-1:0]  req_b;

  logic [N-1:0]     rdy_a  [3];
  logic [N-1:0]     rsv_a  [3];
  logic [127:0]     rsp_a  [3];
  logic             busy_a [3];
  logic             mv_a   [3];

  int   chk_cnt;
  int   pass_cnt;
  int   cyc;
  int   m_ptr;
  hs_t  hist[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three copies of the design, MUL_LATENCY = 1, 2, 4, on shared stimulus,
  // each with its own behavioural multiplier of matching latency.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    mul_arbiter_if #(.NUM_REQ(N)) bus ();
    logic [127:0] pipe [L];

    assign bus.req_valid   = req_valid;
    assign bus.req_a       = req_a;
    assign bus.req_b       = req_b;
    assign bus.mul_product = pipe[L-1];

    always @(posedge clk) begin
      pipe[0] <= {64'd0, bus.mul_a} * {64'd0, bus.mul_b};
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bus)
    );

    assign rdy_a[g]  = bus.req_ready;
    assign rsv_a[g]  = bus.rsp_valid;
    assign rsp_a[g]  = bus.rsp_product;
    assign busy_a[g] = bus.busy;
    assign mv_a[g]   = bus.mul_valid;
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  function automatic logic [63:0] a_sl(int i);
    return req_a[i*64 +: 64];
  endfunction

  function automatic logic [63:0] b_sl(int i);
    return req_b[i*64 +: 64];
  endfunction

  // Reference: round-robin winner for the current inputs, -1 for none.
  function automatic int exp_grant();
    if (reset || !enable) return -1;
    for (int o = 1; o <= N; o++) begin
      if (req_valid[(m_ptr + o) % N]) return (m_ptr + o) % N;
    end
    return -1;
  endfunction

  // Reference {req_ready, rsp_valid, rsp_product, busy} for latency copy k.
  // A response appears 1+L cycles after its handshake; the unit is busy from
  // the cycle after the handshake until the response cycle inclusive.
  function automatic logic [2*N+128:0] exp_vec(int k);
    logic [N-1:0] rdy;
    logic [N-1:0] rsv;
    logic [127:0] p;
    logic         b;
    int           g;
    int           L;
    rdy = '0; rsv = '0; p = '0; b = 1'b0;
    g = exp_grant();
    L = lat_of(k);
    if (g >= 0) rdy[g] = 1'b1;
    foreach (hist[i]) begin
      if (hist[i].hs + 1 + L == cyc) begin
        rsv[hist[i].idx] = 1'b1;
        p = hist[i].prod;
      end
      if (cyc >= hist[i].hs + 1 && cyc <= hist[i].hs + 1 + L) b = 1'b1;
    end
    return {rdy, rsv, p, b};
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = (r == -1) ? i : -2;
    return r;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*64 +: 64] = {$urandom(), $urandom()};
      req_b[i*64 +: 64] = {$urandom(), $urandom()};
    end
  endtask

  // Advance one clock, updating the reference model with this cycle's inputs.
  task automatic tick();
    int g;
    g = exp_grant();
    if (g >= 0) begin
      hist.push_back('{cyc, g, {64'd0, a_sl(g)} * {64'd0, b_sl(g)}});
      m_ptr = g;
    end
    if (reset) begin
      hist.delete();
      m_ptr = N - 1;
    end
    while (hist.size() > 0 && hist[0].hs + 8 < cyc) void'(hist.pop_front());
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; req_valid = '1; rand_ops();
    tick(); tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if (rdy_a[k] !== '0)
        $display("FAIL reset_ready lat=%0d got=%b required=0000", lat_of(k), rdy_a[k]);
      else pass_cnt++;
    end
    tick();
    reset = 1'b0; req_valid = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if ({rsv_a[k], rsp_a[k], busy_a[k], mv_a[k]} !== '0)
        $display("FAIL reset_outputs lat=%0d got rsv=%b prod=%h busy=%b mv=%b required all zero",
                 lat_of(k), rsv_a[k], rsp_a[k], busy_a[k], mv_a[k]);
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_single();
    for (int c = 0; c < 8; c++) begin
      rand_ops();
      req_valid = (c == 0) ? 4'b0001 : 4'b0000;
      req_a[63:0] = 64'd3;
      req_b[63:0] = 64'd5;
      #1;
      for (int k = 0; k < 3; k++) begin
        chk_cnt++;
        if ({rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]} !== exp_vec(k))
          $display("FAIL single lat=%0d cyc=%0d got=%h required=%h", lat_of(k), cyc,
                   {rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]}, exp_vec(k));
        else pass_cnt++;
        if (c == 0) begin
          chk_cnt++;
          if (rdy_a[k] !== 4'b0001)
            $display("FAIL single_ready lat=%0d got=%b required=0001", lat_of(k), rdy_a[k]);
          else pass_cnt++;
        end
        if (c == 1) begin
          chk_cnt++;
          if (mv_a[k] !== 1'b1)
            $display("FAIL single_mul_valid lat=%0d got=%b required=1", lat_of(k), mv_a[k]);
          else pass_cnt++;
        end
        if (c == 1 + lat_of(k)) begin
          chk_cnt++;
          if (rsv_a[k] !== 4'b0001 || rsp_a[k] !== 128'd15)
            $display("FAIL single_rsp lat=%0d got rsv=%b prod=%0d required rsv=0001 prod=15",
                     lat_of(k), rsv_a[k], rsp_a[k]);
          else pass_cnt++;
        end
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    int order[$];
    int cnt[N];
    int gi;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    reset = 1'b1; req_valid = '0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      rand_ops();
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      for (int k = 0; k < 3; k++) begin
        chk_cnt++;
        if ({rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]} !== exp_vec(k))
          $display("FAIL fairness lat=%0d cyc=%0d got=%h required=%h", lat_of(k), cyc,
                   {rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]}, exp_vec(k));
        else pass_cnt++;
      end
      if (c < 8) begin
        gi = onehot_idx(rdy_a[1]);
        chk_cnt++;
        if (gi != c % N)
          $display("FAIL fairness_grant step=%0d got=%0d required=%0d", c, gi, c % N);
        else pass_cnt++;
      end
      for (int i = 0; i < N; i++) begin
        if (rsv_a[1][i]) begin
          cnt[i]++;
          order.push_back(i);
        end
      end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      chk_cnt++;
      if (cnt[i] != 2)
        $display("FAIL fairness_pulses req=%0d got=%0d required=2", i, cnt[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (order.size() != 8)
      $display("FAIL fairness_order_len got=%0d required=8", order.size());
    else begin
      pass_cnt++;
      for (int j = 0; j < 8; j++) begin
        chk_cnt++;
        if (order[j] != j % N)
          $display("FAIL fairness_order pos=%0d got=%0d required=%0d", j, order[j], j % N);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 10; c++) begin
      rand_ops();
      req_valid = (c < 4) ? 4'b0001 : 4'b0000;
      #1;
      for (int k = 0; k < 3; k++) begin
        chk_cnt++;
        if ({rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]} !== exp_vec(k))
          $display("FAIL back_to_back lat=%0d cyc=%0d got=%h required=%h", lat_of(k), cyc,
                   {rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]}, exp_vec(k));
        else pass_cnt++;
        if (c < 4) begin
          chk_cnt++;
          if (rdy_a[k] !== 4'b0001)
            $display("FAIL back_to_back_ready lat=%0d got=%b required=0001", lat_of(k), rdy_a[k]);
          else pass_cnt++;
        end
      end
      tick();
    end
  endtask

  task automatic test_full_width();
    for (int c = 0; c < 7; c++) begin
      rand_ops();
      req_valid = (c == 0) ? 4'b0100 : 4'b0000;
      req_a[128 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
      req_b[128 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      for (int k = 0; k < 3; k++) begin
        chk_cnt++;
        if ({rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]} !== exp_vec(k))
          $display("FAIL full_width lat=%0d cyc=%0d got=%h required=%h", lat_of(k), cyc,
                   {rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]}, exp_vec(k));
        else pass_cnt++;
        if (c == 1 + lat_of(k)) begin
          chk_cnt++;
          if (rsv_a[k] !== 4'b0100 || rsp_a[k] !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001)
            $display("FAIL full_width_rsp lat=%0d got rsv=%b prod=%h required rsv=0100 prod=fffffffffffffffe0000000000000001",
                     lat_of(k), rsv_a[k], rsp_a[k]);
          else pass_cnt++;
        end
      end
      tick();
    end
  endtask

  task automatic test_enable_drop();
    int pulses[3];
    for (int k = 0; k < 3; k++) pulses[k] = 0;
    for (int c = 0; c < 11; c++) begin
      rand_ops();
      enable    = !(c >= 2 && c < 5);
      req_valid = (c < 2) ? 4'b0011 : ((c < 5) ? 4'b1111 : 4'b0000);
      #1;
      for (int k = 0; k < 3; k++) begin
        chk_cnt++;
        if ({rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]} !== exp_vec(k))
          $display("FAIL enable_drop lat=%0d cyc=%0d got=%h required=%h", lat_of(k), cyc,
                   {rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]}, exp_vec(k));
        else pass_cnt++;
        if (!enable) begin
          chk_cnt++;
          if (rdy_a[k] !== '0)
            $display("FAIL enable_drop_ready lat=%0d got=%b required=0000", lat_of(k), rdy_a[k]);
          else pass_cnt++;
        end
        pulses[k] += $countones(rsv_a[k]);
      end
      tick();
    end
    enable = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if (pulses[k] != 2 || busy_a[k] !== 1'b0)
        $display("FAIL enable_drop_done lat=%0d got pulses=%0d busy=%b required pulses=2 busy=0",
                 lat_of(k), pulses[k], busy_a[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_flush();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 9; c++) begin
      rand_ops();
      reset     = (c == 1);
      req_valid = (c == 0) ? 4'b0010 : ((c == 8) ? 4'b1111 : 4'b0000);
      #1;
      for (int k = 0; k < 3; k++) begin
        chk_cnt++;
        if ({rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]} !== exp_vec(k))
          $display("FAIL reset_flush lat=%0d cyc=%0d got=%h required=%h", lat_of(k), cyc,
                   {rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]}, exp_vec(k));
        else pass_cnt++;
        pulses += $countones(rsv_a[k]);
        if (c == 8) begin
          chk_cnt++;
          if (rdy_a[k] !== 4'b0001)
            $display("FAIL reset_flush_grant lat=%0d got=%b required=0001", lat_of(k), rdy_a[k]);
          else pass_cnt++;
        end
      end
      tick();
    end
    chk_cnt++;
    if (pulses != 0)
      $display("FAIL reset_flush_rsp got=%0d pulses required=0", pulses);
    else pass_cnt++;
    req_valid = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rand_ops();
      if ($urandom_range(0, 5) == 0) begin
        req_a[64*$urandom_range(0, N-1) +: 64] = '1;
        req_b[64*$urandom_range(0, N-1) +: 64] = '1;
      end
      req_valid = N'($urandom());
      enable    = ($urandom_range(0, 7) != 0);
      reset     = ($urandom_range(0, 39) == 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        chk_cnt++;
        if ({rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]} !== exp_vec(k))
          $display("FAIL random lat=%0d cyc=%0d got=%h required=%h", lat_of(k), cyc,
                   {rdy_a[k], rsv_a[k], rsp_a[k], busy_a[k]}, exp_vec(k));
        else pass_cnt++;
      end
      tick();
    end
    reset = 1'b0; enable = 1'b1; req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d simulation did not finish in time", cyc);
    $fatal(1);
  end

  initial begin
    chk_cnt = 0; pass_cnt = 0; cyc = 0; m_ptr = N - 1;
    reset = 1'b1; enable = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_full_width();
    test_enable_drop();
    test_reset_flush();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
